// File: rtl/lsu_dmem.sv
// rtl/lsu_dmem.sv - load/store unit driving a req/gnt/rvalid data-memory port
module lsu_dmem #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        dma_en_i,
  input  logic [3:0]  d_size_i,
  input  logic        d_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        load_valid_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o,
  output logic        invalid_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  // Counter holds the number of REQ+WAIT cycles already spent; at least 8 bits.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    a_q;
  logic [3:0]    size_q;
  logic          uns_q;
  logic [CW-1:0] cnt_q;

  logic start, size_legal, is_invalid, is_misaligned;
  logic accept, capture, timeout;
  logic lv_d, mis_d, inv_d, berr_d;
  logic [31:0] lane, ext;

  assign start      = (mem_read_i | mem_write_i) & ~dma_en_i;
  assign size_legal = (d_size_i == 4'b0001) | (d_size_i == 4'b0011) | (d_size_i == 4'b1111);
  assign is_invalid = ~size_legal | (mem_read_i & mem_write_i);
  assign is_misaligned = ((d_size_i == 4'b0011) & addr_i[0]) |
                         ((d_size_i == 4'b1111) & (addr_i[1:0] != 2'b00));

  assign stall_o    = ((state_q == IDLE) & start) | (state_q == REQ) | (state_q == WAIT);
  assign dmem_req_o = (state_q == REQ);

  // Halfwords are always halfword aligned here, so one byte-granular shift serves both widths.
  always_comb begin
    lane = dmem_rdata_i >> {a_q, 3'b000};
    case (size_q)
      4'b0001: ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
      4'b0011: ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
      default: ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    lv_d    = 1'b0;
    mis_d   = 1'b0;
    inv_d   = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_invalid) begin
            inv_d   = 1'b1;
            state_d = DONE;
          end else if (is_misaligned) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            accept  = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          state_d = dmem_we_o ? DONE : WAIT;
        end else if (cnt_q >= CNT_LAST) begin
          timeout = 1'b1;
          berr_d  = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          capture = 1'b1;
          lv_d    = 1'b1;
          state_d = DONE;
        end else if (cnt_q >= CNT_LAST) begin
          timeout = 1'b1;
          berr_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      a_q          <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      cnt_q        <= '0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      load_data_o  <= '0;
      load_valid_o <= 1'b0;
      misaligned_o <= 1'b0;
      invalid_o    <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_valid_o <= lv_d;
      misaligned_o <= mis_d;
      invalid_o    <= inv_d;
      bus_err_o    <= berr_d;
      if (accept) begin
        dmem_addr_o  <= {addr_i[31:2], 2'b00};
        dmem_we_o    <= mem_write_i;
        dmem_be_o    <= d_size_i << addr_i[1:0];
        dmem_wdata_o <= wdata_i << {addr_i[1:0], 3'b000};
        a_q          <= addr_i[1:0];
        size_q       <= d_size_i;
        uns_q        <= d_unsigned_i;
        cnt_q        <= '0;
      end else if ((state_q == REQ) || (state_q == WAIT)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture) begin
        load_data_o <= ext;
      end else if (timeout) begin
        load_data_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem.sv
// tb/tb_lsu_dmem.sv - directed and randomized checks of lsu_dmem against a reference model
module tb_lsu_dmem;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        mem_read, mem_write, dma_en, d_unsigned;
  logic [3:0]  d_size;
  logic [31:0] addr, wdata, rdata;
  logic        gnt, rvalid;
  logic        to_read, to_write, to_gnt, to_rvalid;

  logic        stall, load_valid, misaligned, invalid, bus_err, req, we;
  logic [31:0] load_data, daddr, dwdata;
  logic [3:0]  be;

  logic        t_stall, t_lv, t_mis, t_inv, t_berr, t_req, t_we;
  logic [31:0] t_ld, t_addr, t_wdata;
  logic [3:0]  t_be;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  lsu_dmem dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_read_i(mem_read), .mem_write_i(mem_write), .dma_en_i(dma_en),
    .d_size_i(d_size), .d_unsigned_i(d_unsigned), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall), .load_valid_o(load_valid), .load_data_o(load_data),
    .misaligned_o(misaligned), .invalid_o(invalid), .bus_err_o(bus_err),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(daddr), .dmem_be_o(be),
    .dmem_wdata_o(dwdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata)
  );

  lsu_dmem #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_read_i(to_read), .mem_write_i(to_write), .dma_en_i(dma_en),
    .d_size_i(d_size), .d_unsigned_i(d_unsigned), .addr_i(addr), .wdata_i(wdata),
    .stall_o(t_stall), .load_valid_o(t_lv), .load_data_o(t_ld),
    .misaligned_o(t_mis), .invalid_o(t_inv), .bus_err_o(t_berr),
    .dmem_req_o(t_req), .dmem_we_o(t_we), .dmem_addr_o(t_addr), .dmem_be_o(t_be),
    .dmem_wdata_o(t_wdata), .dmem_gnt_i(to_gnt), .dmem_rvalid_i(to_rvalid), .dmem_rdata_i(rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(logic [3:0] sz, logic uns, logic [1:0] a, logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * a);
    if (sz == 4'h1) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 4'h3) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(logic [3:0] sz, logic [1:0] a);
    int n;
    n = (sz == 4'h1) ? 1 : (sz == 4'h3) ? 3 : 15;
    return 4'(n * (2 ** a));
  endfunction

  // One decoder operation; entered and left just after a rising edge in IDLE.
  task automatic op(input logic rd, input logic wr, input logic dma, input logic [3:0] sz,
                    input logic uns, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] rdat, input int gd, input int rvd);
    logic start, inv, mis, ok;
    logic [31:0] exp_wdata;
    start = (rd || wr) && !dma;
    inv   = start && (!(sz == 4'h1 || sz == 4'h3 || sz == 4'hF) || (rd && wr));
    mis   = start && !inv && ((sz == 4'h3 && a[0]) || (sz == 4'hF && a[1:0] != 2'b00));
    ok    = start && !inv && !mis;
    exp_wdata = wd << (8 * a[1:0]);
    mem_read = rd; mem_write = wr; dma_en = dma; d_size = sz; d_unsigned = uns;
    addr = a; wdata = wd; gnt = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    chk("stall_start", stall, start);
    chk("no_stale_lv", load_valid, 1'b0);
    chk("no_stale_err", {misaligned, invalid, bus_err}, 3'b000);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; dma_en = 1'b0;
    addr = $urandom; wdata = $urandom; d_size = 4'($urandom); d_unsigned = 1'($urandom);
    if (!ok) begin
      @(negedge clk);
      chk("misaligned", misaligned, mis);
      chk("invalid", invalid, inv);
      chk("rej_req", req, 1'b0);
      chk("rej_stall", stall, 1'b0);
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      gnt = (i == gd);
      rvalid = 1'($urandom);
      @(negedge clk);
      chk("req_high", req, 1'b1);
      chk("req_stall", stall, 1'b1);
      chk("req_addr", daddr, {a[31:2], 2'b00});
      chk("req_we", we, wr);
      chk("req_be", be, model_be(sz, a[1:0]));
      if (wr) chk("req_wdata", dwdata, exp_wdata);
      @(posedge clk); #1;
      gnt = 1'b0; rvalid = 1'b0;
    end
    if (rd) begin
      for (int i = 0; i <= rvd; i++) begin
        rvalid = (i == rvd);
        rdata  = (i == rvd) ? rdat : $urandom;
        gnt    = 1'($urandom);
        @(negedge clk);
        chk("wait_stall", stall, 1'b1);
        chk("wait_req", req, 1'b0);
        @(posedge clk); #1;
        rvalid = 1'b0; gnt = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_stall", stall, 1'b0);
    chk("done_req", req, 1'b0);
    chk("done_lv", load_valid, rd);
    if (rd) chk("load_data", load_data, model_load(sz, uns, a[1:0], rdat));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] sz;
    logic       r;
    int         k;
    rst_n = 1'b0;
    mem_read = 0; mem_write = 0; dma_en = 0; d_size = 0; d_unsigned = 0;
    addr = 0; wdata = 0; rdata = 0; gnt = 0; rvalid = 0;
    to_read = 0; to_write = 0; to_gnt = 0; to_rvalid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_pulses", {load_valid, misaligned, invalid, bus_err}, 4'b0000);
    chk("rst_we", we, 1'b0);
    chk("rst_addr", daddr, 32'h0);
    chk("rst_be", be, 4'h0);
    chk("rst_wdata", dwdata, 32'h0);
    chk("rst_ldata", load_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Timeout on the short-timeout instance: gnt never comes.
    to_read = 1'b1; d_size = 4'hF; addr = 32'h40;
    @(negedge clk);
    chk("to_stall", t_stall, 1'b1);
    @(posedge clk); #1;
    to_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_req", t_req, 1'b1);
      chk("to_noerr", t_berr, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_berr", t_berr, 1'b1);
    chk("to_req_drop", t_req, 1'b0);
    chk("to_lv", t_lv, 1'b0);
    chk("to_ldata", t_ld, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_berr_once", t_berr, 1'b0);
    @(posedge clk); #1;

    op(0, 1, 0, 4'h1, 0, 32'h1003, 32'h000000AB, 32'h0, 0, 0);
    op(1, 0, 0, 4'h3, 0, 32'h2002, 32'h0, 32'h8001_1234, 0, 0);
    op(1, 0, 0, 4'h3, 1, 32'h2002, 32'h0, 32'h8001_1234, 0, 0);
    op(1, 0, 0, 4'hF, 0, 32'h3001, 32'h0, 32'h0, 0, 0);
    op(0, 1, 0, 4'h0, 0, 32'h3000, 32'h0, 32'h0, 0, 0);
    op(1, 1, 0, 4'hF, 0, 32'h3000, 32'h0, 32'h0, 0, 0);
    op(1, 0, 0, 4'h1, 0, 32'h5005, 32'h0, 32'h1122_8344, 3, 2);
    op(0, 1, 1, 4'hF, 0, 32'h6000, 32'h1234_5678, 32'h0, 0, 0);
    op(1, 0, 0, 4'hF, 0, 32'h7004, 32'h0, 32'hDEAD_BEEF, 1, 0);

    // Reset while waiting for rvalid.
    mem_read = 1'b1; d_size = 4'hF; addr = 32'h100;
    @(posedge clk); #1;
    mem_read = 1'b0; gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", req, 1'b0);
    chk("rst_mid_stall", stall, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("late_rvalid_lv", load_valid, 1'b0);
    @(posedge clk); #1;
    rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid_lv2", load_valid, 1'b0);
    chk("late_rvalid_stall", stall, 1'b0);
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 7);
      sz = (k < 3) ? 4'h1 : (k < 5) ? 4'h3 : (k < 7) ? 4'hF : 4'($urandom);
      r = 1'($urandom);
      op(r, ($urandom_range(0, 9) == 0) ? 1'b1 : ~r, ($urandom_range(0, 7) == 0),
         sz, 1'($urandom), $urandom, $urandom, $urandom,
         $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsu_dmem.md
# lsu_dmem

Load/store unit between the decoder/execute stage and the data-memory bus. It accepts one memory operation at a time from the decoder's control outputs (`mem_read`, `mem_write`, `d_size`, `d_unsigned`) plus the ALU address and the store data. It drives a req/gnt/rvalid data-memory port with byte enables and lane-shifted write data. It stalls the pipeline until the access completes and returns the aligned, sign- or zero-extended load result.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles spent in REQ+WAIT before the access is abandoned with a bus error (must be ≥1).
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `mem_read_i`  in  1  load request from the decoder.
- `mem_write_i`  in  1  store request from the decoder.
- `dma_en_i`  in  1  PIM/DMA instruction; when high the LSU ignores `mem_read_i`/`mem_write_i`.
- `d_size_i`  in  4  byte mask: 0001 byte, 0011 half, 1111 word; any other value is invalid.
- `d_unsigned_i`  in  1  zero-extend the load result when 1.
- `addr_i`  in  32  byte address from the ALU.
- `wdata_i`  in  32  store data, right-aligned.
- `stall_o`  out  1  hold the pipeline.
- `load_valid_o`  out  1  one-cycle pulse; `load_data_o` is valid.
- `load_data_o`  out  32  extended load result.
- `misaligned_o`  out  1  one-cycle pulse: misaligned access was rejected.
- `invalid_o`  out  1  one-cycle pulse: invalid size, or read and write both set.
- `bus_err_o`  out  1  one-cycle pulse: timeout.
- `dmem_req_o`  out  1  bus request.
- `dmem_we_o`  out  1  1 = write.
- `dmem_addr_o`  out  32  word address, bits [1:0] = 00.
- `dmem_be_o`  out  4  byte enables.
- `dmem_wdata_o`  out  32  lane-shifted write data.
- `dmem_gnt_i`  in  1  request accepted.
- `dmem_rvalid_i`  in  1  read data valid.
- `dmem_rdata_i`  in  32  read data.

## Operation
- FSM has four states: IDLE, REQ, WAIT, DONE.
- **Start condition:** `start = (mem_read_i | mem_write_i) & ~dma_en_i`, evaluated only in IDLE.
- **IDLE, start, access legal:**
  - Register `dmem_addr_o = {addr_i[31:2],2'b00}`, `dmem_we_o = mem_write_i`, `dmem_be_o = d_size_i << addr_i[1:0]`, `dmem_wdata_o = wdata_i << 8*addr_i[1:0]`.
  - Latch `addr_i[1:0]`, `d_size_i`, `d_unsigned_i`.
  - Go to REQ.
- **IDLE, start, rejected:** go to DONE with the matching error flag set; no bus access.
  - Misaligned: half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - Invalid: size not one of the three legal encodings, or `mem_read_i & mem_write_i`.
  - Invalid takes priority over misaligned.
- **REQ:** `dmem_req_o` = 1. All `dmem_*` outputs are held stable until `dmem_gnt_i`.
  - On gnt with a write: go to DONE.
  - On gnt with a read: go to WAIT.
- **WAIT:** on `dmem_rvalid_i`, capture the extended data into `load_data_o` and go to DONE.
  - Byte: lane `rdata[8*a+7:8*a]`.
  - Half: `rdata[16*a[1]+15:16*a[1]]`.
  - Sign-extend unless `d_unsigned` is set.
- **DONE:**
  - Pulse `load_valid_o` (reads only) or the error flag.
  - Go to IDLE unconditionally. Decoder inputs are ignored in this cycle.
- **Timeout:** an 8+-bit counter clears on entry to REQ and increments each cycle in REQ/WAIT. When it reaches `TIMEOUT_CYCLES` without the awaited gnt/rvalid:
  - Drop `dmem_req_o`.
  - Set `load_data_o` = 0.
  - Go to DONE with `bus_err_o`.
- **Stray bus inputs:** `dmem_rvalid_i` outside WAIT and `dmem_gnt_i` outside REQ are ignored.

## Timing
- **`stall_o` (combinational):** `(IDLE & start) | REQ | WAIT`. It is 0 in DONE, so the pipeline advances in the DONE cycle.
- **Read, zero-wait bus** (start at cycle N, gnt at N+1, rvalid at N+2): `dmem_req_o` high in N+1, DONE in N+3. Stall is high N..N+2.
- **Write, zero-wait bus:** `dmem_req_o` high in N+1, DONE in N+2.
- **Rejected access:** stall high in N only; error pulse in N+1.
- **Reset values:** state IDLE; all outputs 0. `stall_o` = 0 given no op.
- **Reset mid-access:** `dmem_req_o` drops immediately (asynchronous). A late rvalid after reset is ignored.
- **Back-to-back accesses:** the next operation can start in the cycle after DONE.

## Test plan
- **Store byte:** `mem_write`, size 0001, `addr` 0x1003, `wdata` 0xAB, gnt on first REQ cycle → `dmem_addr_o` 0x1000, `be` 1000, `wdata` 0xAB000000; stall high for exactly 2 cycles.
- **Signed load half:** size 0011, `addr` 0x2002, `rdata` 0x8001_1234 → `load_data_o` 0xFFFF8001. Repeat with `d_unsigned` → 0x00008001.
- **Misaligned load word:** size 1111 at `addr` 0x3001 → `misaligned_o` pulses once, `dmem_req_o` never asserted. Size 0000 with `mem_write` → `invalid_o` pulses instead.
- **Delayed handshake:** gnt withheld 3 cycles, then rvalid after 2 more → `dmem_*` outputs stable throughout REQ; `load_valid_o` pulses exactly once.
- **Timeout:** `TIMEOUT_CYCLES` = 4, gnt never asserted → `bus_err_o` pulse in the cycle after 4 REQ cycles; `dmem_req_o` then 0.
- **Reset and DMA gating:** reset asserted in WAIT → `dmem_req_o`/`stall_o` = 0 at once, and a later rvalid produces no `load_valid_o`. `dma_en_i` with `mem_write_i` → no bus activity.
